// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, defaults and helpers for the FIFO write arbiter
package fifo_arb_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_STALL} arb_state_t;
   localparam int DEF_FIFO_DEPTH = 32;
   localparam int MAX_REQ = 8;
   function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
      return MAX_REQ'(1) << idx;
   endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: round-robin pick of the first requester at or after i_ptr, wrapping
//   i_req   requester vector
//   i_ptr   highest-priority index
//   o_valid any requester present
//   o_idx   chosen requester index
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic            o_valid,
   output logic [IW-1:0]   o_idx
);
   logic [2*NREQ-1:0] w_dbl;
   logic [IW:0]       w_j;
   assign w_dbl = {i_req, i_req};
   // scanning the doubled vector from i_ptr upward gives the wrap for free;
   // descending loop lets the lowest offset win
   always_comb begin
      o_valid = 1'b0;
      o_idx = '0;
      w_j = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         w_j = {1'b0, i_ptr} + (IW+1)'(i);
         if (w_dbl[w_j]) begin
            o_valid = 1'b1;
            o_idx = (w_j >= (IW+1)'(NREQ)) ? IW'(w_j - (IW+1)'(NREQ)) : IW'(w_j);
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited sharing of one FIFO write port
//   CLOCK, RESET        clock, synchronous active-high reset
//   REQ/DATA/ACK        per-producer valid, packed words, combinational accept
//   GNT                 registered one-hot owner, zero when idle
//   F_FULL_N, USE_DW    FIFO not-full flag and occupancy
//   WRITE, DATA_IN      registered FIFO write strobe and data
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW = 8,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int MAX_BURST = 4
) (
   input  logic                          CLOCK,
   input  logic                          RESET,
   input  logic [NREQ-1:0]               REQ,
   input  logic [NREQ*DW-1:0]            DATA,
   output logic [NREQ-1:0]               ACK,
   output logic [NREQ-1:0]               GNT,
   input  logic                          F_FULL_N,
   input  logic [$clog2(FIFO_DEPTH)-1:0] USE_DW,
   output logic                          WRITE,
   output logic [DW-1:0]                 DATA_IN
);
   localparam int IW = $clog2(NREQ);
   localparam int UW = $clog2(FIFO_DEPTH);
   arb_state_t      r_state, w_state_nxt;
   logic [IW-1:0]   r_idx, r_ptr, w_pick_idx;
   logic [3:0]      r_cnt;
   logic [NREQ-1:0] r_gnt;
   logic            r_write;
   logic [DW-1:0]   r_data_in;
   logic [DW-1:0]   w_words [NREQ];
   logic            w_pick_valid, w_space_ok, w_req_g, w_accept, w_last, w_release, w_grant;
   for (genvar k = 0; k < NREQ; k++) begin : g_words
      assign w_words[k] = DATA[k*DW +: DW];
   end
   rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
      .i_req(REQ),
      .i_ptr(r_ptr),
      .o_valid(w_pick_valid),
      .o_idx(w_pick_idx)
   );
   // the write already in flight has not reached USE_DW yet, so count it as occupied
   assign w_space_ok = F_FULL_N &
      (({1'b0, USE_DW} + {{UW{1'b0}}, r_write}) < (UW+1)'(FIFO_DEPTH - 1));
   assign w_req_g  = REQ[r_idx];
   assign w_accept = (r_state == ST_BURST) & w_req_g & w_space_ok;
   assign w_last   = (r_cnt + 4'd1) == 4'(MAX_BURST);
   assign ACK      = w_accept ? r_gnt : '0;
   assign GNT      = r_gnt;
   assign WRITE    = r_write;
   assign DATA_IN  = r_data_in;
   always_comb begin
      w_state_nxt = r_state;
      w_release = 1'b0;
      w_grant = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_grant = w_pick_valid;
            w_state_nxt = w_pick_valid ? ST_BURST : ST_IDLE;
         end
         ST_BURST: begin
            w_release = (w_accept & w_last) | ~w_req_g;
            w_state_nxt = w_release ? ST_IDLE : (w_space_ok ? ST_BURST : ST_STALL);
         end
         ST_STALL: begin
            w_release = ~w_req_g;
            w_state_nxt = w_release ? ST_IDLE : (w_space_ok ? ST_BURST : ST_STALL);
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_idx <= '0;
         r_ptr <= '0;
         r_cnt <= '0;
         r_gnt <= '0;
         r_write <= 1'b0;
         r_data_in <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_write <= w_accept;
         if (w_accept) r_data_in <= w_words[r_idx];
         if (w_accept) r_cnt <= r_cnt + 4'd1;
         if (w_grant) begin
            r_idx <= w_pick_idx;
            r_gnt <= NREQ'(onehot(3'(w_pick_idx)));
            r_cnt <= '0;
         end
         if (w_release) begin
            r_gnt <= '0;
            r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
         end
      end
   end
endmodule
